key_conditioner: RTL



---
 rtl/key_cond_pkg.sv | 23 ++
 rtl/key_channel.sv | 114 +++++++++++
 rtl/key_conditioner.sv | 34 +++
 3 files changed

// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared types and constants for the push-button conditioner
package key_cond_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_REPEAT,
        S_RELEASE_WAIT
    } key_state_e;

    localparam int KEY_DOWN   = 0;
    localparam int KEY_UP     = 1;
    localparam int KEY_BACK   = 2;
    localparam int KEY_SELECT = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: 2-flop synchroniser, debounce/repeat FSM, registered outputs
// Auto-repeat is built only when KEY_COND_REPEAT_EN is defined.
module key_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REPEAT_DELAY    = 65536,
    parameter int REPEAT_RATE     = 16384,
    parameter bit REPEAT_ON       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press,
    output logic o_level
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_COND_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
`endif

    logic             sync1;
    logic             sync2;
    logic             p;
    key_state_e       state;
    logic [CNT_W-1:0] cnt;

    assign p = ~sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            o_press <= 1'b0;
            o_level <= 1'b0;
        end else begin
            sync1   <= i_key_n;
            sync2   <= sync1;
            o_press <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (p) begin
                        state <= S_PRESS_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_PRESS_WAIT: begin
                    if (!p) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= S_HELD;
                        cnt     <= '0;
                        o_press <= 1'b1;
                        o_level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!p) begin
                        state <= S_RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
`ifdef KEY_COND_REPEAT_EN
                    end else if (REPEAT_ON && cnt == RD_LAST) begin
                        state   <= S_REPEAT;
                        cnt     <= '0;
                        o_press <= 1'b1;
`endif
                    end else if (cnt != '1) begin
                        // Saturating hold time; only reaches the top when repeat is off.
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef KEY_COND_REPEAT_EN
                S_REPEAT: begin
                    if (!p) begin
                        state <= S_RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
                    end else if (cnt == RR_LAST) begin
                        cnt     <= '0;
                        o_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_RELEASE_WAIT: begin
                    if (p) begin
                        // Release bounce: still held, repeat timing starts over.
                        state <= S_HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        o_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced press/repeat pulses for the four DE2 push-buttons
// Auto-repeat is built only when KEY_COND_REPEAT_EN is defined.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int                N_KEYS          = 4,
    parameter int                DEBOUNCE_CYCLES = 1024,
    parameter int                REPEAT_DELAY    = 65536,
    parameter int                REPEAT_RATE     = 16384,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = 4'b0011
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_level
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_ON       (REPEAT_MASK[g])
        ) u_channel (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_key_n (i_key_n[g]),
            .o_press (o_press[g]),
            .o_level (o_level[g])
        );
    end

endmodule
